load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the pipeline's memory stage and the word-organised data memory; converts RV32I load/store requests (byte, halfword, word) into word-wide memory reads and writes. Sub-word stores use a read-merge-write sequence because the memory only has a single word-wide write enable. Loads are extracted, sign- or zero-extended, and returned as a registered, single-cycle response pulse. Misaligned and illegal requests are reported without touching memory.

## Interface
- DEPTH_WORDS, 64, data-memory depth in 32-bit words; used only by the bounds check
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge with req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 encoding
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid only with rsp_valid; set for misaligned, illegal, or out-of-range requests
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address, `{addr_q[31:2], 2'b00}`
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data; combinational from mem_addr

## Operation
- Legal loads:
  - LB = 000, LH = 001, LW = 010, LBU = 100, LHU = 101.
- Legal stores:
  - SB = 000, SH = 001, SW = 010.
  - Any other funct3 sets err.
- Misaligned requests set err:
  - halfword accesses with addr[0] = 1;
  - word accesses with addr[1:0] ≠ 0.
- On acceptance, capture we, funct3, addr and wdata into registers.
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, go to RESP(err) if the request has an error.
  - Otherwise: load → LOAD; SW → WRITE with mem_wd = wdata; SB/SH → MERGE.
- LOAD: select byte/halfword at addr[1:0], extend per funct3 into rsp_rdata_q → RESP.
- MERGE: replace the addressed byte lanes of mem_rd with wdata[7:0] (SB) or wdata[15:0] (SH) into wd_q → WRITE.
- WRITE: mem_we = 1 for exactly this cycle → RESP.
- RESP: rsp_valid = 1 for one cycle → IDLE. No response backpressure.
- Lane mapping is little-endian:
  - byte k = word[8k+7:8k];
  - halfword at addr[1] = 1 = word[31:16].
- Errored requests never assert mem_we.

## Timing
- Request accepted at the end of cycle 0.
- Loads:
  - cycle 1 LOAD; cycle 2 rsp_valid.
- SW:
  - cycle 1 mem_we; cycle 2 rsp_valid.
- SB/SH:
  - cycle 1 MERGE (memory read); cycle 2 mem_we; cycle 3 rsp_valid.
- Errors: cycle 1 rsp_valid with rsp_err = 1.
- Earliest next acceptance is the cycle after RESP, so back-to-back loads take 3 cycles each.
- mem_we is decoded combinationally from state. Reset mid-operation returns the FSM to IDLE asynchronously and drops mem_we immediately; a pending merge is abandoned with no write.
- Reset values:
  - state IDLE; req_ready 1; mem_we 0.
  - rsp_valid 0; rsp_err 0; rsp_rdata 0.
  - mem_addr 0; mem_wd 0.

## Configuration
- LSU_BOUNDS_CHECK_EN defined:
  - a request with addr[31:2] ≥ DEPTH_WORDS is treated as an error (RESP with err, no memory access).
- Undefined:
  - no range check;
  - the address passes through and the memory indexes whatever it decodes.

## Test plan
- Memory word 1 = 0x8001_7FF5:
  - LB 0x4 → rsp_rdata 0xFFFF_FFF5, err 0, valid 2 cycles after accept.
  - LBU 0x4 → 0x0000_00F5.
  - LH 0x6 → 0xFFFF_8001.
  - LHU 0x6 → 0x0000_8001.
- Word 2 = 0x1122_3344:
  - SB 0x9, wdata 0xAB → one mem_we pulse with mem_wd 0x1122_AB44, then LW 0x8 returns 0x1122_AB44.
  - SH 0xA, wdata 0xBEEF → mem_wd 0xBEEF_3344.
- Misaligned requests:
  - LW 0x6 → rsp_err 1, rsp_rdata 0, 1-cycle latency.
  - SH 0x5 → rsp_err 1, no mem_we ever asserted.
  - funct3 011 load → err.
- Reset mid-operation: drive rst_n low during MERGE of SB 0x0 → mem_we stays 0, word 0 unchanged, req_ready 1, rsp_valid 0.
- LSU_BOUNDS_CHECK_EN defined, DEPTH_WORDS 64:
  - SW 0x100 → err, no write.
  - SW 0xFC, wdata 0xDEAD_BEEF → write succeeds, err 0.
- Handshake: hold req_valid high continuously with 3 queued LWs → acceptances spaced 3 cycles apart, exactly one rsp_valid per request in order.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/halfword/word accesses over a word-wide data memory.
// Optional LSU_BOUNDS_CHECK_EN flags requests beyond DEPTH_WORDS as errors.
module load_store_unit #(
   parameter int unsigned DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MERGE = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wd;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_illegal;
   logic        w_misalign;
   logic        w_oob;
   logic        w_req_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   assign w_accept = req_valid & req_ready;

   // Request legality: loads accept the unsigned variants, stores do not
   always_comb begin
      w_illegal = 1'b1;
      case (req_funct3)
         F3_B, F3_H, F3_W: w_illegal = 1'b0;
         F3_BU, F3_HU:     w_illegal = req_we;
         default:          w_illegal = 1'b1;
      endcase
   end

   assign w_misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                       ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
   assign w_oob      = BOUNDS_EN & ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign w_req_err  = w_illegal | w_misalign | w_oob;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_req_err)                     w_next = S_RESP;
               else if (!req_we)                  w_next = S_LOAD;
               else if (req_funct3[1:0] == 2'b10) w_next = S_WRITE;
               else                               w_next = S_MERGE;
            end
         end
         S_LOAD:  w_next = S_RESP;
         S_MERGE: w_next = S_WRITE;
         S_WRITE: w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake and memory strobe decoded straight from the state register
   always_comb begin
      req_ready = 1'b0;
      mem_we    = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      case (r_state)
         S_IDLE:  req_ready = 1'b1;
         S_WRITE: mem_we    = 1'b1;
         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = r_err;
         end
         default: ;
      endcase
   end

   // Little-endian lane selection for loads
   always_comb begin
      w_byte = mem_rd[7:0];
      case (r_addr[1:0])
         2'd0: w_byte = mem_rd[7:0];
         2'd1: w_byte = mem_rd[15:8];
         2'd2: w_byte = mem_rd[23:16];
         2'd3: w_byte = mem_rd[31:24];
         default: w_byte = mem_rd[7:0];
      endcase
   end

   assign w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

   always_comb begin
      w_load_data = 32'd0;
      case (r_funct3)
         F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
         F3_W:    w_load_data = mem_rd;
         F3_BU:   w_load_data = {24'd0, w_byte};
         F3_HU:   w_load_data = {16'd0, w_half};
         default: w_load_data = 32'd0;
      endcase
   end

   // Sub-word store: overlay the new lanes on the word just read
   always_comb begin
      w_merged = mem_rd;
      if (r_funct3[1:0] == 2'b00) begin
         case (r_addr[1:0])
            2'd0: w_merged[7:0]   = r_wd[7:0];
            2'd1: w_merged[15:8]  = r_wd[7:0];
            2'd2: w_merged[23:16] = r_wd[7:0];
            2'd3: w_merged[31:24] = r_wd[7:0];
            default: w_merged = mem_rd;
         endcase
      end else if (r_addr[1]) begin
         w_merged[31:16] = r_wd[15:0];
      end else begin
         w_merged[15:0] = r_wd[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_funct3 <= 3'd0;
         r_addr   <= 32'd0;
         r_wd     <= 32'd0;
         r_rdata  <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wd     <= req_wdata;
                  r_rdata  <= 32'd0;
                  r_err    <= w_req_err;
               end
            end
            S_LOAD:  r_rdata <= w_load_data;
            S_MERGE: r_wd    <= w_merged;
            default: ;
         endcase
      end
   end

   assign mem_addr  = {r_addr[31:2], 2'b00};
   assign mem_wd    = r_wd;
   assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

   localparam int unsigned DEPTH = 64;
`ifdef LSU_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;

   logic [31:0] tb_mem  [128];
   logic [31:0] ref_mem [128];
   logic        ld_en = 1'b0;
   logic [6:0]  ld_idx = 7'd0;
   logic [31:0] ld_val = 32'd0;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] o_rd, o_wd, o_addr;
   logic        o_err;
   int          o_lat, o_we;

   always #5 clk = ~clk;

   load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // Word memory: combinational read, synchronous write
   assign mem_rd = tb_mem[mem_addr[8:2]];
   always @(posedge clk) begin
      if (ld_en)       tb_mem[ld_idx] <= ld_val;
      else if (mem_we) tb_mem[mem_addr[8:2]] <= mem_wd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 7'(idx); ld_val = val;
      @(posedge clk);
      #1 ld_en = 1'b0;
      ref_mem[idx] = val;
   endtask

   // Reference: what one request should do, from size, alignment and lane arithmetic
   task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                         output logic e_we, output logic [31:0] e_wd, output int e_lat);
      int          n, sh, idx;
      logic        legal;
      logic [63:0] m64;
      logic [31:0] mask, w, val;
      n     = 1 << f3[1:0];
      sh    = 8 * int'(addr[1:0]);
      idx   = int'(addr[8:2]);
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e_err = !legal || (int'(addr % 32'(n)) != 0) || (BOUNDS && (addr >> 2) >= DEPTH);
      e_rd  = 32'd0; e_we = 1'b0; e_wd = 32'd0;
      m64   = (64'd1 << (8 * n)) - 64'd1;
      mask  = m64[31:0];
      w     = ref_mem[idx];
      if (e_err) begin
         e_lat = 1;
      end else if (!we) begin
         val = (w >> sh) & mask;
         if (!f3[2] && n < 4 && val[8*n-1]) val = val | ~mask;
         e_rd  = val;
         e_lat = 2;
      end else begin
         mask  = mask << sh;
         e_wd  = (w & ~mask) | ((wd << sh) & mask);
         e_we  = 1'b1;
         e_lat = (n == 4) ? 2 : 3;
         ref_mem[idx] = e_wd;
      end
   endtask

   task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      logic        e_err, e_we;
      logic [31:0] e_rd, e_wd;
      int          e_lat, k;
      ref_op(we, f3, addr, wd, e_err, e_rd, e_we, e_wd, e_lat);
      @(negedge clk);
      k = 0;
      while (!req_ready && k < 10) begin @(negedge clk); k++; end
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      o_we = 0; o_lat = 0; o_err = 1'b0; o_rd = 32'hDEAD_0000; o_wd = 32'd0; o_addr = 32'd0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (mem_we) begin o_we++; o_wd = mem_wd; o_addr = mem_addr; end
         if (rsp_valid) begin o_lat = c; o_err = rsp_err; o_rd = rsp_rdata; break; end
      end
      chk({tag, "_lat"},   32'(o_lat), 32'(e_lat));
      chk({tag, "_err"},   32'(o_err), 32'(e_err));
      chk({tag, "_rdata"}, o_rd, e_rd);
      chk({tag, "_wecnt"}, 32'(o_we), e_we ? 32'd1 : 32'd0);
      if (e_we) begin
         chk({tag, "_wd"},    o_wd, e_wd);
         chk({tag, "_waddr"}, o_addr, {addr[31:2], 2'b00});
      end
      chk({tag, "_memword"}, tb_mem[addr[8:2]], ref_mem[addr[8:2]]);
   endtask

   initial begin : main
      int          acc_cyc [3];
      logic [31:0] b2b_exp [3];
      int          n_acc, n_rsp, we_seen;
      logic        acc_now;
      logic [2:0]  f3;
      logic [31:0] a;

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      for (int i = 0; i < 128; i++) preload(i, $urandom);
      preload(1, 32'h8001_7FF5);
      preload(2, 32'h1122_3344);

      // Reset values
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wd", mem_wd, 32'd0);
      rst_n = 1'b1;

      // Load extraction and extension
      do_op("lb",  1'b0, 3'b000, 32'h4, 32'h0); chk("lb_const",  o_rd, 32'hFFFF_FFF5);
      do_op("lbu", 1'b0, 3'b100, 32'h4, 32'h0); chk("lbu_const", o_rd, 32'h0000_00F5);
      do_op("lh",  1'b0, 3'b001, 32'h6, 32'h0); chk("lh_const",  o_rd, 32'hFFFF_8001);
      do_op("lhu", 1'b0, 3'b101, 32'h6, 32'h0); chk("lhu_const", o_rd, 32'h0000_8001);
      chk("lb_lat_const", 32'(o_lat), 32'd2);

      // Sub-word stores
      do_op("sb", 1'b1, 3'b000, 32'h9, 32'h0000_00AB); chk("sb_wd_const", o_wd, 32'h1122_AB44);
      do_op("lw_after_sb", 1'b0, 3'b010, 32'h8, 32'h0); chk("lw_const", o_rd, 32'h1122_AB44);
      preload(2, 32'h1122_3344);
      do_op("sh", 1'b1, 3'b001, 32'hA, 32'h0000_BEEF); chk("sh_wd_const", o_wd, 32'hBEEF_3344);
      chk("sh_lat_const", 32'(o_lat), 32'd3);

      // Errors
      do_op("lw_mis", 1'b0, 3'b010, 32'h6, 32'h0);
      chk("lw_mis_err_const", 32'(o_err), 32'd1); chk("lw_mis_lat_const", 32'(o_lat), 32'd1);
      do_op("sh_mis", 1'b1, 3'b001, 32'h5, 32'hFFFF);
      chk("sh_mis_we_const", 32'(o_we), 32'd0);
      do_op("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'h0); chk("f3_011_err_const", 32'(o_err), 32'd1);
      do_op("st_f3_100", 1'b1, 3'b100, 32'h0, 32'h0);

      // Reset while MERGE is in progress
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h5A; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      we_seen = mem_we ? 1 : 0;
      rst_n = 1'b0;
      #1;
      chk("mrst_mem_we", 32'(mem_we), 32'd0);
      chk("mrst_ready", 32'(req_ready), 32'd1);
      chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
      for (int c = 0; c < 4; c++) begin @(negedge clk); if (mem_we) we_seen++; end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin @(negedge clk); if (mem_we || rsp_valid) we_seen++; end
      chk("mrst_no_write", 32'(we_seen), 32'd0);
      chk("mrst_word0", tb_mem[0], ref_mem[0]);

      // Range check around the top of memory
      do_op("sw_oob", 1'b1, 3'b010, 32'h100, 32'h1234_5678);
      chk("sw_oob_err_const", 32'(o_err), BOUNDS ? 32'd1 : 32'd0);
      do_op("sw_top", 1'b1, 3'b010, 32'hFC, 32'hDEAD_BEEF);
      chk("sw_top_err_const", 32'(o_err), 32'd0);
      chk("sw_top_mem_const", tb_mem[63], 32'hDEAD_BEEF);

      // Back-to-back loads with req_valid held high
      for (int i = 0; i < 3; i++) b2b_exp[i] = ref_mem[i + 1];
      @(negedge clk);
      n_acc = 0; n_rsp = 0;
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4; req_valid = 1'b1;
      for (int c = 0; c < 30 && n_rsp < 3; c++) begin
         if (c > 0) @(negedge clk);
         if (rsp_valid) begin
            chk($sformatf("b2b_rdata%0d", n_rsp), rsp_rdata, b2b_exp[n_rsp]);
            n_rsp++;
         end
         acc_now = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (acc_now) begin
            acc_cyc[n_acc] = c;
            n_acc++;
            if (n_acc < 3) req_addr = 32'(4 * (n_acc + 1));
            else           req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("b2b_nacc", 32'(n_acc), 32'd3);
      chk("b2b_nrsp", 32'(n_rsp), 32'd3);
      if (n_acc == 3) begin
         chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
         chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
      end

      // Random mix
      for (int i = 0; i < 60; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, 71) * 4);
         if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
         do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), f3, a, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
